// File: rtl/shift_right_seq.sv
// Iterative right shifter: one bit per clock, logical or arithmetic fill,
// start/ready/done handshake toward the control unit.
module shift_right_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sreg, sreg_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic               fmode, fmode_nxt;

  // State, datapath and handshake flags; flags are decoded from the next state
  // so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      fmode <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      fmode <= fmode_nxt;
      ready <= (state_nxt == IDLE);
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE_S);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    fmode_nxt = fmode;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_nxt  = data_in;
          cnt_nxt   = shamt;
          fmode_nxt = arith;
          state_nxt = (shamt == '0) ? DONE_S : SHIFT;
        end
      end
      SHIFT: begin
        // sign bit never moves out of the MSB, so it is the fill for sra
        sreg_nxt = {fmode & sreg[WIDTH-1], sreg[WIDTH-1:1]};
        cnt_nxt  = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) state_nxt = DONE_S;
      end
      DONE_S:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign result = sreg;

endmodule
